// File: rtl/sdr_user_ctrl_pkg.sv
// Shared types and constants for the SDRAM user command stage.
package sdr_user_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_RD_REQ  = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_DONE    = 3'd4,
        ST_ERR     = 3'd5
    } state_t;

    localparam int ADDR_W_DEF = 24;
    localparam int DATA_W_DEF = 16;

    // LEDR bit positions
    localparam int LED_BUSY   = 0;
    localparam int LED_DONE   = 1;
    localparam int LED_ERR    = 2;
    localparam int LED_WR     = 3;
    localparam int LED_CNT_LO = 4;
    localparam int LED_CNT_HI = 9;

    // SW field positions
    localparam int SW_OP     = 9;
    localparam int SW_COL_HI = 8;
    localparam int SW_COL_LO = 4;
    localparam int COL_W     = SW_COL_HI - SW_COL_LO + 1;

    // States in which the wait counter runs and a timeout can fire
    function automatic logic is_wait_state(input state_t s);
        return (s == ST_WR_REQ) || (s == ST_RD_REQ) || (s == ST_RD_WAIT);
    endfunction

endpackage

// File: rtl/sdr_user_ctrl_if.sv
// Request/acknowledge bus between the user command stage and the SDRAM controller core.
interface sdr_user_ctrl_if
    import sdr_user_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              wr_req;
    logic              wr_ack;
    logic              rd_req;
    logic              rd_ack;
    logic              rd_valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;

    // User side: issues requests
    modport master (
        output wr_req, rd_req, addr, wr_data,
        input  wr_ack, rd_ack, rd_valid, rd_data
    );

    // Controller side: answers requests
    modport slave (
        input  wr_req, rd_req, addr, wr_data,
        output wr_ack, rd_ack, rd_valid, rd_data
    );
endinterface

// File: rtl/sdr_user_ctrl_key_debounce.sv
// Pushbutton conditioner: 2-FF synchroniser, stability counter and a one-cycle
// press pulse on the debounced released->pressed transition.
module key_debounce
    import sdr_user_pkg::*;
#(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic press
);
    localparam int CNT_W = $clog2(DEB_CYCLES + 1);

    logic             meta_r;
    logic             sync_r;
    logic             level_r;
    logic             press_r;
    logic [CNT_W-1:0] cnt_r;

    // Bring the asynchronous key into the clock domain; idle level is released (high)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= 1'b1;
            sync_r <= 1'b1;
        end else begin
            meta_r <= key_raw;
            sync_r <= meta_r;
        end
    end

    // Accept a new level only after DEB_CYCLES consecutive differing samples; pulse on press
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= {CNT_W{1'b0}};
            level_r <= 1'b1;
            press_r <= 1'b0;
        end else begin
            press_r <= 1'b0;
            if (sync_r == level_r) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (cnt_r == CNT_W'(DEB_CYCLES - 1)) begin
                cnt_r   <= {CNT_W{1'b0}};
                level_r <= sync_r;
                press_r <= ~sync_r;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    assign press = press_r;

endmodule

// File: rtl/sdr_user_ctrl.sv
// User command stage: turns each debounced key press into one SDRAM write or
// read, runs the req/ack handshake, keeps the last data word for the display
// and reports status on LEDR. A request is held for at most TIMEOUT_CYC cycles.
module sdr_user_ctrl
    import sdr_user_pkg::*;
#(
    parameter int DEB_CYCLES  = 1_000_000,
    parameter int TIMEOUT_CYC = 65_535,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic [9:0]           SW,
    input  logic                 KEY,
    sdr_user_ctrl_if.master      sdr,
    output logic [DATA_W-1:0]    disp_data,
    output logic [9:0]           LEDR
);
    localparam int WC_W = $clog2(TIMEOUT_CYC + 1);

    state_t            state_r;
    state_t            state_nx;
    logic              press_s;
    logic              capture_s;
    logic              timeout_s;
    logic              wr_ack_hit_s;
    logic              rd_ack_hit_s;
    logic              rd_take_s;
    logic [WC_W-1:0]   wait_cnt_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wr_data_r;
    logic [DATA_W-1:0] disp_r;
    logic              wr_req_r;
    logic              rd_req_r;
    logic              busy_r;
    logic              done_r;
    logic              err_r;
    logic              last_wr_r;
    logic [5:0]        press_cnt_r;

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key_debounce (
        .clk     (sys_clk),
        .rst_n   (sys_rst_n),
        .key_raw (KEY),
        .press   (press_s)
    );

    // Presses outside IDLE are dropped; acks only count in the state that expects them
    assign capture_s    = (state_r == ST_IDLE) && press_s;
    assign timeout_s    = (wait_cnt_r == WC_W'(TIMEOUT_CYC - 1));
    assign wr_ack_hit_s = (state_r == ST_WR_REQ) && sdr.wr_ack;
    assign rd_ack_hit_s = (state_r == ST_RD_REQ) && sdr.rd_ack;
    assign rd_take_s    = ((state_r == ST_RD_WAIT) || rd_ack_hit_s) && sdr.rd_valid;

    // State register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Next-state decode; a handshake in the timeout cycle wins over the timeout
    always_comb begin
        state_nx = state_r;
        case (state_r)
            ST_IDLE: begin
                if (capture_s) begin
                    state_nx = SW[SW_OP] ? ST_WR_REQ : ST_RD_REQ;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_WR_REQ: begin
                if (wr_ack_hit_s) begin
                    state_nx = ST_DONE;
                end else if (timeout_s) begin
                    state_nx = ST_ERR;
                end else begin
                    state_nx = ST_WR_REQ;
                end
            end
            ST_RD_REQ: begin
                if (rd_take_s) begin
                    state_nx = ST_DONE;
                end else if (rd_ack_hit_s) begin
                    state_nx = ST_RD_WAIT;
                end else if (timeout_s) begin
                    state_nx = ST_ERR;
                end else begin
                    state_nx = ST_RD_REQ;
                end
            end
            ST_RD_WAIT: begin
                if (rd_take_s) begin
                    state_nx = ST_DONE;
                end else if (timeout_s) begin
                    state_nx = ST_ERR;
                end else begin
                    state_nx = ST_RD_WAIT;
                end
            end
            ST_DONE: state_nx = ST_IDLE;
            ST_ERR:  state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Wait counter: restarts on every state change, runs only while waiting on the controller
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wait_cnt_r <= {WC_W{1'b0}};
        end else if (state_nx != state_r) begin
            wait_cnt_r <= {WC_W{1'b0}};
        end else if (is_wait_state(state_r)) begin
            wait_cnt_r <= wait_cnt_r + WC_W'(1);
        end else begin
            wait_cnt_r <= {WC_W{1'b0}};
        end
    end

    // Capture command fields at an accepted press; they stay frozen while a request is out
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            addr_r      <= {ADDR_W{1'b0}};
            wr_data_r   <= {DATA_W{1'b0}};
            last_wr_r   <= 1'b0;
            press_cnt_r <= 6'd0;
        end else if (capture_s) begin
            addr_r      <= {{(ADDR_W - COL_W){1'b0}}, SW[SW_COL_HI:SW_COL_LO]};
            wr_data_r   <= {(DATA_W / 4){SW[3:0]}};
            last_wr_r   <= SW[SW_OP];
            press_cnt_r <= press_cnt_r + 6'd1;
        end else begin
            addr_r      <= addr_r;
            wr_data_r   <= wr_data_r;
            last_wr_r   <= last_wr_r;
            press_cnt_r <= press_cnt_r;
        end
    end

    // Done/error flags: set on entry to DONE/ERR, held until the next accepted press
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
        end else if (capture_s) begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
        end else if (state_nx == ST_DONE) begin
            done_r <= 1'b1;
        end else if (state_nx == ST_ERR) begin
            err_r <= 1'b1;
        end else begin
            done_r <= done_r;
            err_r  <= err_r;
        end
    end

    // Display word: written data on write ack, returned data on read completion
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            disp_r <= {DATA_W{1'b0}};
        end else if (wr_ack_hit_s) begin
            disp_r <= wr_data_r;
        end else if (rd_take_s) begin
            disp_r <= sdr.rd_data;
        end else begin
            disp_r <= disp_r;
        end
    end

    // Requests and busy registered from the next state so they drop the cycle after ack/timeout
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_req_r <= 1'b0;
            rd_req_r <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            wr_req_r <= (state_nx == ST_WR_REQ);
            rd_req_r <= (state_nx == ST_RD_REQ);
            busy_r   <= (state_nx != ST_IDLE);
        end
    end

    assign sdr.wr_req  = wr_req_r;
    assign sdr.rd_req  = rd_req_r;
    assign sdr.addr    = addr_r;
    assign sdr.wr_data = wr_data_r;
    assign disp_data   = disp_r;

    assign LEDR[LED_CNT_HI:LED_CNT_LO] = press_cnt_r;
    assign LEDR[LED_WR]                = last_wr_r;
    assign LEDR[LED_ERR]               = err_r;
    assign LEDR[LED_DONE]              = done_r;
    assign LEDR[LED_BUSY]              = busy_r;

endmodule

// File: tb/tb_sdr_user_ctrl.sv
// Bench for sdr_user_ctrl: directed key presses against a controller model,
// with a per-cycle transaction-level scoreboard and literal end-of-test checks.
module tb_sdr_user_ctrl;
    localparam int DEB = 8;
    localparam int TMO = 32;

    logic        clk;
    logic        rst_n;
    logic [9:0]  SW;
    logic        KEY;
    logic [15:0] disp_data;
    logic [9:0]  LEDR;

    sdr_user_ctrl_if #(.ADDR_W(24), .DATA_W(16)) bus ();

    sdr_user_ctrl #(.DEB_CYCLES(DEB), .TIMEOUT_CYC(TMO), .ADDR_W(24), .DATA_W(16)) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .SW        (SW),
        .KEY       (KEY),
        .sdr       (bus),
        .disp_data (disp_data),
        .LEDR      (LEDR)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Controller model settings
    bit          wr_ack_en = 1'b1;
    bit          rd_ack_en = 1'b1;
    int          vdly      = 2;
    logic [15:0] rdat      = 16'h0000;
    int          spur_req  = 0;

    // Controller model: ack 3 cycles into a request, rd_valid vdly cycles after ack
    initial begin
        int wr_age;
        int rd_age;
        int vcnt;
        int spur_done;
        wr_age = 0; rd_age = 0; vcnt = 0; spur_done = 0;
        bus.wr_ack = 1'b0; bus.rd_ack = 1'b0; bus.rd_valid = 1'b0; bus.rd_data = 16'h0000;
        forever begin
            @(posedge clk); #1;
            bus.wr_ack = 1'b0; bus.rd_ack = 1'b0; bus.rd_valid = 1'b0;
            if (!rst_n) begin
                wr_age = 0; rd_age = 0; vcnt = 0; spur_done = spur_req;
            end else begin
                wr_age = bus.wr_req ? wr_age + 1 : 0;
                rd_age = bus.rd_req ? rd_age + 1 : 0;
                if (wr_ack_en && wr_age == 3) bus.wr_ack = 1'b1;
                if (rd_ack_en && rd_age == 3) begin
                    bus.rd_ack = 1'b1;
                    if (vdly == 0) begin
                        bus.rd_valid = 1'b1; bus.rd_data = rdat;
                    end else begin
                        vcnt = vdly;
                    end
                end else if (vcnt > 0) begin
                    vcnt--;
                    if (vcnt == 0) begin
                        bus.rd_valid = 1'b1; bus.rd_data = rdat;
                    end
                end
                if (spur_done != spur_req) begin
                    spur_done = spur_req;
                    bus.wr_ack = 1'b1;
                end
            end
        end
    end

    // Expected command of the press the bench intends to be accepted
    logic [23:0] m_addr  = 24'h0;
    logic [15:0] m_wdata = 16'h0;
    bit          m_op_wr = 1'b0;
    int          rises_total = 0;

    // Scoreboard: transaction-level expectations checked every cycle
    initial begin
        bit          p_wr, p_rd, p_wack, p_rack, rd_infl, m_wr, any, p_any, hs;
        int          run, m_cnt;
        logic [15:0] m_disp;
        p_wr = 0; p_rd = 0; p_wack = 0; p_rack = 0; rd_infl = 0; m_wr = 0;
        run = 0; m_cnt = 0; m_disp = 16'h0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                p_wr = 0; p_rd = 0; p_wack = 0; p_rack = 0; rd_infl = 0; m_wr = 0;
                run = 0; m_cnt = 0; m_disp = 16'h0;
            end else begin
                any   = bus.wr_req | bus.rd_req;
                p_any = p_wr | p_rd;
                hs    = (p_wack & p_wr) | (p_rack & p_rd);
                if (any && !p_any) begin
                    m_cnt = (m_cnt + 1) % 64;
                    m_wr  = bus.wr_req;
                    rises_total++;
                    run = 0;
                end
                if (!any && p_any && !hs) chk("timeout_len", run, TMO);
                if (p_wack && p_wr) chk("wr_drop_after_ack", bus.wr_req, 1'b0);
                if (p_rack && p_rd) chk("rd_drop_after_ack", bus.rd_req, 1'b0);
                chk("disp_data", disp_data, m_disp);
                chk("ledr_cnt", LEDR[9:4], m_cnt);
                chk("ledr_last_wr", LEDR[3], m_wr);
                if (any) begin
                    run++;
                    chk("req_exclusive", bus.wr_req & bus.rd_req, 1'b0);
                    chk("req_type", bus.wr_req, m_op_wr);
                    chk("req_addr", bus.addr, m_addr);
                    chk("busy_with_req", LEDR[0], 1'b1);
                    chk("req_within_timeout", run <= TMO, 1'b1);
                    if (bus.wr_req) chk("req_wr_data", bus.wr_data, m_wdata);
                end
                if (bus.wr_req && bus.wr_ack) m_disp = m_wdata;
                if (bus.rd_req && bus.rd_ack) rd_infl = 1'b1;
                if (bus.rd_valid && rd_infl) begin
                    m_disp  = bus.rd_data;
                    rd_infl = 1'b0;
                end
                p_wr = bus.wr_req; p_rd = bus.rd_req; p_wack = bus.wr_ack; p_rack = bus.rd_ack;
            end
        end
    end

    task automatic set_cmd(input logic [9:0] sw);
        SW      = sw;
        m_op_wr = sw[9];
        m_addr  = {19'h0, sw[8:4]};
        m_wdata = {4{sw[3:0]}};
    endtask

    task automatic key_set(input logic v);
        @(posedge clk); #1;
        KEY = v;
    endtask

    task automatic wait_req(input int bound);
        int k = 0;
        @(negedge clk);
        while (!(bus.wr_req | bus.rd_req) && k < bound) begin
            @(negedge clk);
            k++;
        end
        chk("req_seen", bus.wr_req | bus.rd_req, 1'b1);
    endtask

    task automatic wait_idle(input int bound);
        int k = 0;
        @(negedge clk);
        while (LEDR[0] && k < bound) begin
            @(negedge clk);
            k++;
        end
        chk("idle_reached", LEDR[0], 1'b0);
    endtask

    // Directed sequence
    initial begin
        int base;
        rst_n = 1'b0; KEY = 1'b1; SW = 10'h000;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ledr", LEDR, 10'h000);
        chk("rst_disp", disp_data, 16'h0000);
        chk("rst_wr_req", bus.wr_req, 1'b0);
        chk("rst_rd_req", bus.rd_req, 1'b0);
        chk("rst_addr", bus.addr, 24'h0);

        // 1: three short bounces are not presses
        base = rises_total;
        for (int i = 0; i < 3; i++) begin
            key_set(1'b0);
            repeat (4) @(posedge clk);
            key_set(1'b1);
            repeat (10) @(posedge clk);
        end
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("bounce_no_req", rises_total - base, 0);
        chk("bounce_ledr", LEDR, 10'h000);

        // 2: write col 5, nibble A
        set_cmd(10'b1_00101_1010);
        key_set(1'b0);
        wait_req(30);
        chk("wr_req_up", bus.wr_req, 1'b1);
        chk("wr_addr", bus.addr, 24'h000005);
        chk("wr_data", bus.wr_data, 16'hAAAA);
        key_set(1'b1);
        wait_idle(100);
        chk("wr_disp", disp_data, 16'hAAAA);
        chk("wr_ledr", LEDR, 10'h01A);
        repeat (14) @(posedge clk);

        // 3: read col 5, controller returns AAAA
        set_cmd(10'b0_00101_0000);
        rdat = 16'hAAAA; vdly = 2;
        key_set(1'b0);
        wait_req(30);
        chk("rd_req_up", bus.rd_req, 1'b1);
        key_set(1'b1);
        wait_idle(100);
        chk("rd_disp", disp_data, 16'hAAAA);
        chk("rd_ledr", LEDR, 10'h022);
        repeat (14) @(posedge clk);

        // 3b: rd_valid in the same cycle as rd_ack
        set_cmd(10'b0_00011_0000);
        rdat = 16'h1234; vdly = 0;
        key_set(1'b0);
        wait_req(30);
        key_set(1'b1);
        wait_idle(100);
        chk("rd0_disp", disp_data, 16'h1234);
        chk("rd0_ledr", LEDR, 10'h032);
        repeat (14) @(posedge clk);

        // 4: read never acked -> timeout error, display kept
        set_cmd(10'b0_00111_0000);
        rd_ack_en = 1'b0;
        key_set(1'b0);
        wait_req(30);
        key_set(1'b1);
        wait_idle(100);
        chk("tmo_ledr", LEDR, 10'h044);
        chk("tmo_disp", disp_data, 16'h1234);
        rd_ack_en = 1'b1;
        repeat (14) @(posedge clk);

        // 5: press and spurious wr_ack during RD_WAIT are ignored; error cleared by new press
        set_cmd(10'b0_01001_0000);
        rdat = 16'hBEEF; vdly = 28;
        key_set(1'b0);
        wait_req(30);
        chk("err_cleared", LEDR[2], 1'b0);
        key_set(1'b1);
        repeat (10) @(posedge clk);
        spur_req++;
        SW = 10'b1_11111_1111;
        key_set(1'b0);
        repeat (12) @(posedge clk);
        key_set(1'b1);
        wait_idle(100);
        chk("ign_ledr", LEDR, 10'h052);
        chk("ign_disp", disp_data, 16'hBEEF);
        base = rises_total;
        repeat (30) @(posedge clk);
        chk("ign_no_req", rises_total - base, 0);

        // 6: reset while a write request is pending
        set_cmd(10'b1_11111_0101);
        wr_ack_en = 1'b0;
        key_set(1'b0);
        wait_req(30);
        key_set(1'b1);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_mid_wr_req", bus.wr_req, 1'b0);
        chk("rst_mid_ledr", LEDR, 10'h000);
        chk("rst_mid_disp", disp_data, 16'h0000);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        wr_ack_en = 1'b1;
        base = rises_total;
        repeat (30) @(posedge clk);
        @(negedge clk);
        chk("post_rst_no_req", rises_total - base, 0);
        chk("post_rst_ledr", LEDR, 10'h000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global guard so the run always ends
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "timeout");
    end

endmodule
